ysyx_25020037_mem_arbiter: RTL and testbench
============================================

# ysyx_25020037_mem_arbiter

Two-requester memory-port arbiter between the instruction-cache refill port and the load/store unit (LSU), driving the core's single external memory port. Transactions are granted round-robin on conflict and are strictly one-at-a-time. Every grant completes: with the memory's data, or with an error response if the memory does not acknowledge within a bounded number of cycles.

## Interface
- ADDR_WIDTH, 32, address width
- DATA_WIDTH, 32, data width
- TIMEOUT, 256, cycles a granted transaction waits for mem_ack before error completion (≥2)
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- if_req  in  1  icache refill request, level, held until if_ready
- if_addr  in  ADDR_WIDTH  refill address, stable while if_req
- if_rdata  out  DATA_WIDTH  refill data, valid with if_ready
- if_ready  out  1  one-cycle completion pulse
- if_err  out  1  timeout flag, valid with if_ready
- ls_req  in  1  LSU request, level, held until ls_ready
- ls_wen  in  1  1 = write, 0 = read
- ls_addr  in  ADDR_WIDTH  LSU address
- ls_wdata  in  DATA_WIDTH  write data
- ls_wmask  in  DATA_WIDTH/8  byte-enable mask
- ls_rdata  out  DATA_WIDTH  read data; 0 on write completion
- ls_ready  out  1  one-cycle completion pulse
- ls_err  out  1  timeout flag, valid with ls_ready
- mem_req  out  1  memory request, level, held until mem_ack or timeout
- mem_wen, mem_addr, mem_wdata, mem_wmask  out  1/ADDR_WIDTH/DATA_WIDTH/DATA_WIDTH/8  registered copy of the granted request; IF grants drive mem_wen=0, mem_wmask=0, mem_wdata=0
- mem_rdata  in  DATA_WIDTH  read data, valid with mem_ack
- mem_ack  in  1  one-cycle completion from memory

## Operation
- States:
  - IDLE: samples requests.
  - BUSY_IF / BUSY_LS: mem_req=1.
  - DONE: completion pulse; requests are ignored.
- IDLE transitions:
  - Only if_req → BUSY_IF.
  - Only ls_req → BUSY_LS.
  - Both → the side not recorded in last_gnt (last_gnt: 0 = IF last, 1 = LS last; reset 0, so LS wins the first conflict).
  - last_gnt updates on every grant.
- Granting latches the requester's address, wen, wdata and wmask into mem_* registers. Requester inputs are not read again for that transaction.
- BUSY_x with mem_ack=1 → DONE:
  - Capture mem_rdata, or 0 for LS writes, into x_rdata.
  - Set x_ready=1, x_err=0.
- BUSY_x timeout:
  - wait_cnt counts cycles in BUSY_x and clears on grant.
  - When wait_cnt==TIMEOUT-1 and mem_ack=0 → DONE with x_ready=1, x_err=1, x_rdata=0.
  - mem_ack on that same cycle takes precedence: normal completion.
- DONE → IDLE unconditionally. The DONE cycle absorbs the requester's one-cycle-late req deassertion, so a completed request is never re-granted.
- mem_ack outside BUSY_x is ignored.
- Reset, including mid-transaction:
  - Outputs: all outputs 0 (mem_req, if_ready, ls_ready, if_err, ls_err, all data/addr/mask).
  - Internal: state IDLE, last_gnt 0, wait_cnt 0.
  - The in-flight transaction is dropped with no completion pulse.

## Timing
- All outputs are registered; no combinational input→output path.
- Request seen at IDLE edge N: mem_req=1 and mem_* valid from cycle N+1.
- mem_ack sampled at edge M: x_ready/x_rdata valid for exactly cycle M+1, mem_req=0 from M+1.
- IDLE is re-entered at M+2, so the earliest next grant is at edge M+2.
- Best case: req cycle 0 → mem_req cycle 1 → mem_ack cycle 1 → ready cycle 2 → next grant edge 3.
- Back-to-back conflicting requesters alternate strictly. Neither waits more than one full transaction plus 2 cycles after the other completes.
- x_ready and x_err are pulses: 0 on every cycle other than the DONE cycle of x.

## Test plan
- IF only:
  - Stimulus: if_req=1, if_addr=0x8000_0010; memory acks 3 cycles after mem_req with 0x0051_3093.
  - Required: mem_addr=0x8000_0010, mem_wen=0; if_rdata=0x0051_3093 with a single-cycle if_ready; no second mem_req while if_req drops one cycle late.
- LS write:
  - Stimulus: ls_req=1, ls_wen=1, addr 0x8000_1000, wdata 0xDEAD_BEEF, wmask 0x3.
  - Required: mem_* mirror the request; ls_ready pulse with ls_rdata=0, ls_err=0.
- Conflict:
  - Stimulus: if_req and ls_req both raised in the same cycle after reset, held until their own ready.
  - Required: LS granted first, IF second; with both continuously re-requesting, the grant order is LS, IF, LS, IF.
- Timeout:
  - Stimulus: TIMEOUT=8, LS read, mem_ack never asserted.
  - Required: ls_ready=1, ls_err=1, ls_rdata=0 exactly 8 cycles after mem_req rises; mem_req then 0.
- Ack at limit:
  - Stimulus: TIMEOUT=8, mem_ack arrives on wait cycle 7 with 0x1234_5678.
  - Required: normal completion, err=0, rdata=0x1234_5678.
- Reset mid-transaction:
  - Stimulus: rst_n pulsed low while in BUSY_IF.
  - Required: all outputs 0 immediately (asynchronously), no if_ready pulse; after release, a fresh ls_req is granted normally.

Source files
------------

// File: rtl/ysyx_25020037_mem_arbiter.sv
// rtl/ysyx_25020037_mem_arbiter.sv - round-robin icache/LSU arbiter onto one memory port
// One transaction in flight; every grant completes with data or a timeout error.
module ysyx_25020037_mem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 256
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    if_req,
    input  logic [ADDR_WIDTH-1:0]   if_addr,
    output logic [DATA_WIDTH-1:0]   if_rdata,
    output logic                    if_ready,
    output logic                    if_err,
    input  logic                    ls_req,
    input  logic                    ls_wen,
    input  logic [ADDR_WIDTH-1:0]   ls_addr,
    input  logic [DATA_WIDTH-1:0]   ls_wdata,
    input  logic [DATA_WIDTH/8-1:0] ls_wmask,
    output logic [DATA_WIDTH-1:0]   ls_rdata,
    output logic                    ls_ready,
    output logic                    ls_err,
    output logic                    mem_req,
    output logic                    mem_wen,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    output logic [DATA_WIDTH/8-1:0] mem_wmask,
    input  logic [DATA_WIDTH-1:0]   mem_rdata,
    input  logic                    mem_ack
);
    localparam int CNT_W  = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam int MASK_W = DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_BUSY_IF = 2'd1,
        S_BUSY_LS = 2'd2,
        S_DONE    = 2'd3
    } state_e;

    state_e                  state_q;
    logic                    last_gnt_q;
    logic [CNT_W-1:0]        wait_cnt_q;
    logic                    mem_req_q;
    logic                    mem_wen_q;
    logic [ADDR_WIDTH-1:0]   mem_addr_q;
    logic [DATA_WIDTH-1:0]   mem_wdata_q;
    logic [MASK_W-1:0]       mem_wmask_q;
    logic [DATA_WIDTH-1:0]   if_rdata_q;
    logic                    if_ready_q;
    logic                    if_err_q;
    logic [DATA_WIDTH-1:0]   ls_rdata_q;
    logic                    ls_ready_q;
    logic                    ls_err_q;
    logic                    timeout_hit;
    logic                    finish;

    assign timeout_hit = (wait_cnt_q == CNT_W'(TIMEOUT - 1));
    assign finish      = mem_ack || timeout_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            last_gnt_q  <= 1'b0;
            wait_cnt_q  <= '0;
            mem_req_q   <= 1'b0;
            mem_wen_q   <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wmask_q <= '0;
            if_rdata_q  <= '0;
            if_ready_q  <= 1'b0;
            if_err_q    <= 1'b0;
            ls_rdata_q  <= '0;
            ls_ready_q  <= 1'b0;
            ls_err_q    <= 1'b0;
        end else begin
            if_ready_q <= 1'b0;
            if_err_q   <= 1'b0;
            ls_ready_q <= 1'b0;
            ls_err_q   <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    // On conflict the side that did not win last time goes first.
                    if (ls_req && (!if_req || !last_gnt_q)) begin
                        state_q     <= S_BUSY_LS;
                        last_gnt_q  <= 1'b1;
                        wait_cnt_q  <= '0;
                        mem_req_q   <= 1'b1;
                        mem_wen_q   <= ls_wen;
                        mem_addr_q  <= ls_addr;
                        mem_wdata_q <= ls_wdata;
                        mem_wmask_q <= ls_wmask;
                    end else if (if_req) begin
                        state_q     <= S_BUSY_IF;
                        last_gnt_q  <= 1'b0;
                        wait_cnt_q  <= '0;
                        mem_req_q   <= 1'b1;
                        mem_wen_q   <= 1'b0;
                        mem_addr_q  <= if_addr;
                        mem_wdata_q <= '0;
                        mem_wmask_q <= '0;
                    end
                end
                S_BUSY_IF, S_BUSY_LS: begin
                    if (finish) begin
                        state_q   <= S_DONE;
                        mem_req_q <= 1'b0;
                        if (state_q == S_BUSY_IF) begin
                            if_ready_q <= 1'b1;
                            if_err_q   <= !mem_ack;
                            if_rdata_q <= mem_ack ? mem_rdata : '0;
                        end else begin
                            ls_ready_q <= 1'b1;
                            ls_err_q   <= !mem_ack;
                            ls_rdata_q <= (mem_ack && !mem_wen_q) ? mem_rdata : '0;
                        end
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 1'b1;
                    end
                end
                // One dead cycle lets the requester drop req before IDLE samples again.
                S_DONE:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_wen   = mem_wen_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_wmask = mem_wmask_q;
    assign if_rdata  = if_rdata_q;
    assign if_ready  = if_ready_q;
    assign if_err    = if_err_q;
    assign ls_rdata  = ls_rdata_q;
    assign ls_ready  = ls_ready_q;
    assign ls_err    = ls_err_q;
endmodule

// File: tb/tb_ysyx_25020037_mem_arbiter.sv
// tb/tb_ysyx_25020037_mem_arbiter.sv - scoreboard bench for the icache/LSU memory arbiter
// Memory responder predicts each grant and completion; a separate monitor checks them.
module tb_ysyx_25020037_mem_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MW = 4;
    localparam int T  = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          if_ready, if_err;
    logic          ls_req, ls_wen;
    logic [AW-1:0] ls_addr;
    logic [DW-1:0] ls_wdata;
    logic [MW-1:0] ls_wmask;
    logic [DW-1:0] ls_rdata;
    logic          ls_ready, ls_err;
    logic          mem_req, mem_wen;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [MW-1:0] mem_wmask;
    logic [DW-1:0] mem_rdata;
    logic          mem_ack;

    always #5 clk = ~clk;

    ysyx_25020037_mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(T)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready), .if_err(if_err),
        .ls_req(ls_req), .ls_wen(ls_wen), .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_wmask(ls_wmask),
        .ls_rdata(ls_rdata), .ls_ready(ls_ready), .ls_err(ls_err),
        .mem_req(mem_req), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wmask(mem_wmask), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    typedef struct {
        bit          ls;
        bit          wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wmask;
    } grant_t;

    typedef struct {
        bit          ls;
        bit          err;
        logic [31:0] rdata;
        int          cyc;
    } resp_t;

    grant_t      grant_q[$];
    resp_t       resp_q[$];
    bit          order_q[$];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    bit          model_last = 1'b0;
    bit          seen_if = 1'b0, seen_ls = 1'b0;
    int          forced_lat = -1;
    bit          force_data = 1'b0;
    logic [31:0] forced_data = '0;
    bit          rec_order = 1'b0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic check_outputs_zero(input string name);
        check({name, "_mem"}, {mem_req, mem_wen, mem_addr, mem_wdata, mem_wmask}, '0);
        check({name, "_rsp"}, {if_rdata, if_ready, if_err, ls_rdata, ls_ready, ls_err}, '0);
    endtask

    task automatic if_txn(input logic [31:0] a);
        int n;
        if_addr = a;
        if_req  = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!if_ready && n < 200);
        if (!if_ready) begin
            checks++;
            failures++;
            $display("FAIL if_wait: got no if_ready required if_ready within 200 cycles");
        end
        @(posedge clk);
        #1 if_req = 1'b0;
    endtask

    task automatic ls_txn(input bit w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
        int n;
        ls_wen   = w;
        ls_addr  = a;
        ls_wdata = d;
        ls_wmask = m;
        ls_req   = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ls_ready && n < 200);
        if (!ls_ready) begin
            checks++;
            failures++;
            $display("FAIL ls_wait: got no ls_ready required ls_ready within 200 cycles");
        end
        @(posedge clk);
        #1 ls_req = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst_n = 1'b0;
        grant_q.delete();
        resp_q.delete();
        model_last = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Requests as the arbiter saw them at the most recent rising edge.
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            seen_if = if_req;
            seen_ls = ls_req;
        end
    end

    // Memory responder: predicts who was granted and what each completion must look like.
    initial begin
        int          cnt;
        int          lat;
        logic [31:0] d;
        grant_t      g;
        resp_t       r;
        bit          side;
        cnt = 0;
        lat = 0;
        d = '0;
        mem_ack = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            mem_ack = 1'b0;
            if (!rst_n) begin
                cnt = 0;
            end else if (mem_req) begin
                if (cnt == 0) begin
                    side = (seen_if && seen_ls) ? !model_last : seen_ls;
                    model_last = side;
                    g.ls    = side;
                    g.wen   = side ? ls_wen : 1'b0;
                    g.addr  = side ? ls_addr : if_addr;
                    g.wdata = side ? ls_wdata : 32'h0;
                    g.wmask = side ? ls_wmask : 4'h0;
                    lat = (forced_lat >= 0) ? forced_lat : int'($urandom_range(0, T + 1));
                    d = force_data ? forced_data : $urandom;
                    r.ls    = side;
                    r.err   = (lat >= T);
                    r.rdata = (lat >= T || (side && g.wen)) ? 32'h0 : d;
                    r.cyc   = cyc + 1 + ((lat >= T) ? T - 1 : lat);
                    grant_q.push_back(g);
                    resp_q.push_back(r);
                end
                if (cnt == lat) begin
                    mem_ack = 1'b1;
                    mem_rdata = d;
                end else begin
                    mem_rdata = $urandom;
                end
                cnt++;
            end else begin
                cnt = 0;
                mem_ack = ($urandom_range(0, 5) == 0);
                mem_rdata = $urandom;
            end
        end
    end

    // Monitor: compares every grant and every completion against the scoreboard.
    initial begin
        bit     pm, pif, pls;
        grant_t g;
        resp_t  r;
        pm = 1'b0;
        pif = 1'b0;
        pls = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (!rst_n) begin
                pm = 1'b0;
                pif = 1'b0;
                pls = 1'b0;
            end else begin
                if (mem_req && !pm) begin
                    if (grant_q.size() == 0) begin
                        check("grant_expected", 1'b0, 1'b1);
                    end else begin
                        g = grant_q.pop_front();
                        check("mem_addr", mem_addr, g.addr);
                        check("mem_wen", mem_wen, g.wen);
                        check("mem_wdata", mem_wdata, g.wdata);
                        check("mem_wmask", mem_wmask, g.wmask);
                    end
                end
                check("err_without_ready", {if_err & !if_ready, ls_err & !ls_ready}, 2'b00);
                if (if_ready || ls_ready) begin
                    check("one_ready", if_ready && ls_ready, 1'b0);
                    check("pulse_width", (if_ready && pif) || (ls_ready && pls), 1'b0);
                    check("mem_req_low_at_ready", mem_req, 1'b0);
                    if (rec_order) order_q.push_back(ls_ready);
                    if (resp_q.size() == 0) begin
                        check("ready_expected", 1'b0, 1'b1);
                    end else begin
                        r = resp_q.pop_front();
                        check("ready_side", ls_ready, r.ls);
                        check("ready_err", ls_ready ? ls_err : if_err, r.err);
                        check("ready_rdata", ls_ready ? ls_rdata : if_rdata, r.rdata);
                        check("ready_cycle", cyc, r.cyc);
                    end
                end
                pm = mem_req;
                pif = if_ready;
                pls = ls_ready;
            end
        end
    end

    initial begin
        int n;
        rst_n = 1'b0;
        if_req = 1'b0;
        if_addr = '0;
        ls_req = 1'b0;
        ls_wen = 1'b0;
        ls_addr = '0;
        ls_wdata = '0;
        ls_wmask = '0;
        repeat (3) @(posedge clk);
        #1 check_outputs_zero("reset");
        rst_n = 1'b1;

        // IF only, ack three cycles after mem_req, then no re-grant.
        forced_lat = 3;
        force_data = 1'b1;
        forced_data = 32'h0051_3093;
        if_txn(32'h8000_0010);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("if_no_regrant", mem_req, 1'b0);
        end

        // LS write.
        forced_lat = 1;
        force_data = 1'b0;
        ls_txn(1'b1, 32'h8000_1000, 32'hDEAD_BEEF, 4'h3);

        // Conflict straight after reset: LS, IF, LS, IF.
        do_reset();
        forced_lat = -1;
        rec_order = 1'b1;
        order_q.delete();
        fork
            begin
                ls_txn(1'b0, $urandom, $urandom, 4'hF);
                ls_txn(1'b1, $urandom, $urandom, 4'h5);
            end
            begin
                if_txn($urandom);
                if_txn($urandom);
            end
        join
        rec_order = 1'b0;
        check("order_len", order_q.size(), 4);
        if (order_q.size() == 4) begin
            check("order", {order_q[0], order_q[1], order_q[2], order_q[3]}, 4'b1010);
        end

        // Timeout on an LS read.
        forced_lat = 100;
        ls_txn(1'b0, 32'h8000_2000, 32'h0, 4'h0);
        @(negedge clk);
        check("timeout_mem_req_low", mem_req, 1'b0);

        // Ack on the last wait cycle wins over the timeout.
        forced_lat = T - 1;
        force_data = 1'b1;
        forced_data = 32'h1234_5678;
        ls_txn(1'b0, 32'h8000_3000, 32'h0, 4'h0);
        force_data = 1'b0;

        // Random traffic from both sides.
        forced_lat = -1;
        fork
            for (int i = 0; i < 20; i++) begin
                int g;
                g = $urandom_range(0, 3);
                repeat (g) @(posedge clk);
                if (g != 0) #1;
                ls_txn(1'($urandom), $urandom, $urandom, 4'($urandom));
            end
            for (int j = 0; j < 20; j++) begin
                int g;
                g = $urandom_range(0, 3);
                repeat (g) @(posedge clk);
                if (g != 0) #1;
                if_txn($urandom);
            end
        join

        // Reset in the middle of an IF transaction.
        repeat (3) @(posedge clk);
        #1 forced_lat = 100;
        if_addr = 32'h8000_4000;
        if_req = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!mem_req && n < 50);
        check("midrst_granted", mem_req, 1'b1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_outputs_zero("midrst");
        grant_q.delete();
        resp_q.delete();
        model_last = 1'b0;
        if_req = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        forced_lat = 2;
        ls_txn(1'b0, 32'h8000_5000, 32'h0, 4'h0);
        repeat (4) @(negedge clk);
        check("scoreboard_drained", {grant_q.size(), resp_q.size()}, 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
